matrix_mem_responder: RTL and testbench

Responder side of the matrix-memory bus used by the execution unit. It stores 4x4 matrices of 16-bit elements, one 256-bit matrix per entry. It answers enable/read-not-write requests on the shared 256-bit data bus: it returns a stored matrix on a read and captures the bus into the array on a write. It sits beside the execution unit and ALU on the same bus and drives the bus only while it holds a read.

---
 rtl/matrix_pkg.sv | 23 ++
 rtl/matrix_parity.sv | 18 +
 rtl/matrix_mem_responder.sv | 181 ++++++++++++++++++
 tb/tb_matrix_mem_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix-memory bus: widths, responder state
// encoding and the per-element even-parity helper.
package matrix_pkg;

  localparam int MATRIX_W = 256;
  localparam int ELEM_W   = 16;
  localparam int ELEMS    = 16;
  localparam int ADDR_W   = 8;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    RD_ACCESS    = 3'd1,
    RD_DRIVE     = 3'd2,
    WR_CAPTURE   = 3'd3,
    WAIT_RELEASE = 3'd4
  } mm_state_e;

  // Even-parity bit for one element: element plus this bit has an even count of ones.
  function automatic logic elem_parity(input logic [ELEM_W-1:0] elem);
    return ^elem;
  endfunction

endpackage

// File: rtl/matrix_parity.sv
// Combinational per-element parity of one 256-bit matrix (16 bits out,
// bit i covers element i). Used only when MATRIX_MEM_PARITY_EN is defined.
module matrix_parity
  import matrix_pkg::*;
(
  input  logic [MATRIX_W-1:0] i_data,
  output logic [ELEMS-1:0]    o_par
);

  // One parity bit per 16-bit element.
  always_comb begin
    o_par = {ELEMS{1'b0}};
    for (int i = 0; i < ELEMS; i++) begin
      o_par[i] = elem_parity(i_data[i*ELEM_W +: ELEM_W]);
    end
  end

endmodule

// File: rtl/matrix_mem_responder.sv
// Matrix-memory bus responder: DEPTH x 256-bit array, read/write over a shared
// tri-state bus. Optional per-element parity via MATRIX_MEM_PARITY_EN.
module matrix_mem_responder
  import matrix_pkg::*;
#(
  parameter int DEPTH = 16
)
(
  input  logic                clk,
  input  logic                nReset,
  inout  wire  [MATRIX_W-1:0] dataBus,
  input  logic [ADDR_W-1:0]   address,
  input  logic                nMatrixMemEnable,
  input  logic                ReadnWriteMem,
  output logic                memDone,
  output logic                addrErr,
  output logic                busDrive
`ifdef MATRIX_MEM_PARITY_EN
  ,
  output logic                parityErr
`endif
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

  mm_state_e             r_state;
  mm_state_e             w_next_state;
  logic                  r_acc_stage;
  logic                  w_acc_stage_next;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_en_prev;
  logic [MATRIX_W-1:0]   r_mem [DEPTH];
  logic [MATRIX_W-1:0]   r_rd_buf;
  logic                  r_mem_done;
  logic                  r_addr_err;
  logic                  r_bus_drive;
  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_load_buf;
  logic                  w_write_en;
  logic                  w_done;
  logic                  w_drive_next;
  logic [IDX_W-1:0]      w_idx;

  // A request is a falling enable: the previous sampled edge must have seen it high.
  assign w_accept   = !nMatrixMemEnable && r_en_prev;
  assign w_in_range = ({1'b0, r_addr} < DEPTH_L);
  assign w_idx      = r_addr[IDX_W-1:0];

  assign dataBus  = r_bus_drive ? r_rd_buf : {MATRIX_W{1'bz}};
  assign memDone  = r_mem_done;
  assign addrErr  = r_addr_err;
  assign busDrive = r_bus_drive;

  // Next-state and per-cycle strobes; RD_ACCESS spans two cycles (fetch, then check).
  always_comb begin
    w_next_state     = r_state;
    w_acc_stage_next = 1'b0;
    w_load_buf       = 1'b0;
    w_write_en       = 1'b0;
    w_done           = 1'b0;
    w_drive_next     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (ReadnWriteMem) begin
            w_next_state = RD_ACCESS;
          end else begin
            w_next_state = WR_CAPTURE;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      RD_ACCESS: begin
        if (!r_acc_stage) begin
          w_load_buf       = 1'b1;
          w_acc_stage_next = 1'b1;
        end else begin
          w_next_state = RD_DRIVE;
          w_done       = 1'b1;
          w_drive_next = 1'b1;
        end
      end
      RD_DRIVE: begin
        if (nMatrixMemEnable || !ReadnWriteMem) begin
          w_next_state = IDLE;
        end else begin
          w_drive_next = 1'b1;
        end
      end
      WR_CAPTURE: begin
        w_write_en   = w_in_range;
        w_done       = 1'b1;
        w_next_state = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (nMatrixMemEnable) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = WAIT_RELEASE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Control state, address latch, read buffer and registered outputs.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state     <= IDLE;
      r_acc_stage <= 1'b0;
      r_addr      <= {ADDR_W{1'b0}};
      r_en_prev   <= 1'b1;
      r_rd_buf    <= {MATRIX_W{1'b0}};
      r_mem_done  <= 1'b0;
      r_addr_err  <= 1'b0;
      r_bus_drive <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_acc_stage <= w_acc_stage_next;
      r_en_prev   <= nMatrixMemEnable;
      if ((r_state == IDLE) && w_accept) begin
        r_addr <= address;
      end
      if (w_load_buf) begin
        r_rd_buf <= w_in_range ? r_mem[w_idx] : {MATRIX_W{1'b0}};
      end
      r_mem_done  <= w_done;
      r_addr_err  <= w_done && !w_in_range;
      r_bus_drive <= w_drive_next;
    end
  end

  // Matrix storage; cleared as a whole by reset.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= {MATRIX_W{1'b0}};
      end
    end else if (w_write_en) begin
      r_mem[w_idx] <= dataBus;
    end
  end

`ifdef MATRIX_MEM_PARITY_EN
  logic [ELEMS-1:0] r_par [DEPTH];
  logic [ELEMS-1:0] r_rd_par;
  logic             r_parity_err;
  logic [ELEMS-1:0] w_wr_par;
  logic [ELEMS-1:0] w_chk_par;

  matrix_parity u_par_wr (.i_data(dataBus),  .o_par(w_wr_par));
  matrix_parity u_par_rd (.i_data(r_rd_buf), .o_par(w_chk_par));

  assign parityErr = r_parity_err;

  // Parity stored at write, compared against the buffered entry in the second access cycle.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_par[i] <= {ELEMS{1'b0}};
      end
      r_rd_par     <= {ELEMS{1'b0}};
      r_parity_err <= 1'b0;
    end else begin
      if (w_write_en) begin
        r_par[w_idx] <= w_wr_par;
      end
      if (w_load_buf) begin
        r_rd_par <= w_in_range ? r_par[w_idx] : {ELEMS{1'b0}};
      end
      r_parity_err <= w_done && (r_state == RD_ACCESS) && w_in_range && (w_chk_par != r_rd_par);
    end
  end
`endif

endmodule

// File: tb/tb_matrix_mem_responder.sv
// Self-checking bench for matrix_mem_responder: vector table plus hand-written
// corner sequences; completions are checked against a scoreboard queue.
module tb_matrix_mem_responder;

  logic         clk;
  logic         rst_n;
  wire  [255:0] data_bus;
  logic [255:0] tb_bus;
  logic         tb_drv;
  logic [7:0]   addr;
  logic         n_en;
  logic         rnw;
  logic         mem_done;
  logic         addr_err;
  logic         bus_drive;
`ifdef MATRIX_MEM_PARITY_EN
  logic         parity_err;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic         is_rd;
    logic [255:0] data;
    logic         err;
    logic         perr;
  } sb_t;
  sb_t sbq[$];

  typedef struct {
    logic         rnw;
    logic [7:0]   addr;
    logic [255:0] data;
    logic         exp_err;
  } vec_t;
  vec_t vecs[11];

  logic [255:0] model [16];

  assign data_bus = tb_drv ? tb_bus : {256{1'bz}};

  matrix_mem_responder #(.DEPTH(16)) dut (
    .clk              (clk),
    .nReset           (rst_n),
    .dataBus          (data_bus),
    .address          (addr),
    .nMatrixMemEnable (n_en),
    .ReadnWriteMem    (rnw),
    .memDone          (mem_done),
    .addrErr          (addr_err),
    .busDrive         (bus_drive)
`ifdef MATRIX_MEM_PARITY_EN
    ,
    .parityErr        (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every memDone pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mem_done === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_done: got memDone=1 expected no completion");
      end else begin
        sb_t e;
        e = sbq.pop_front();
        check("sb_addr_err", {255'd0, addr_err}, {255'd0, e.err});
        if (e.is_rd) begin
          check("sb_rd_data", data_bus, e.data);
          check("sb_bus_drive", {255'd0, bus_drive}, 256'd1);
        end
`ifdef MATRIX_MEM_PARITY_EN
        check("sb_parity_err", {255'd0, parity_err}, {255'd0, e.perr});
`endif
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input logic [7:0] a, input logic [255:0] d, input logic exp_err);
    sbq.push_back('{1'b0, 256'd0, exp_err, 1'b0});
    if (a < 8'd16) model[a[3:0]] = d;
    n_en = 1'b0; rnw = 1'b0; addr = a; tb_bus = d; tb_drv = 1'b1;
    @(posedge clk); #1;
    addr = ~a;
    @(posedge clk);
    @(negedge clk);
    check("wr_done", {255'd0, mem_done}, 256'd1);
    tb_drv = 1'b0; n_en = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [255:0] exp_d, input logic exp_err,
                         input logic exp_perr);
    sbq.push_back('{1'b1, exp_d, exp_err, exp_perr});
    n_en = 1'b0; rnw = 1'b1; addr = a;
    @(posedge clk); #1;
    addr = ~a;
    @(negedge clk);
    check("rd_no_early_done", {255'd0, mem_done}, 256'd0);
    @(posedge clk);
    @(negedge clk);
    check("rd_no_early_drive", {255'd0, bus_drive}, 256'd0);
    @(posedge clk);
    @(negedge clk);
    check("rd_done_at_n2", {255'd0, mem_done}, 256'd1);
    @(posedge clk);
    @(negedge clk);
    check("rd_done_once", {255'd0, mem_done}, 256'd0);
    check("rd_drive_held", {255'd0, bus_drive}, 256'd1);
    check("rd_data_held", data_bus, exp_d);
    n_en = 1'b1;
    @(posedge clk); #1;
    check("rd_release", {255'd0, bus_drive}, 256'd0);
  endtask

  initial begin
    logic [255:0] pat;
    logic [255:0] ones;
    ones = {256{1'b1}};
    pat  = 256'd0;
    for (int i = 0; i < 16; i++) pat[255-16*i -: 16] = 16'(i + 1);
    for (int i = 0; i < 16; i++) model[i] = 256'd0;

    vecs[0]  = '{1'b0, 8'd3,   pat,               1'b0};
    vecs[1]  = '{1'b0, 8'd0,   {8{32'hDEADBEEF}}, 1'b0};
    vecs[2]  = '{1'b0, 8'd15,  {16{16'hA5C3}},    1'b0};
    vecs[3]  = '{1'b0, 8'd20,  ones,              1'b1};
    vecs[4]  = '{1'b1, 8'd3,   pat,               1'b0};
    vecs[5]  = '{1'b1, 8'd0,   {8{32'hDEADBEEF}}, 1'b0};
    vecs[6]  = '{1'b1, 8'd15,  {16{16'hA5C3}},    1'b0};
    vecs[7]  = '{1'b1, 8'd20,  256'd0,            1'b1};
    vecs[8]  = '{1'b1, 8'd1,   256'd0,            1'b0};
    vecs[9]  = '{1'b0, 8'd255, ones,              1'b1};
    vecs[10] = '{1'b1, 8'd255, 256'd0,            1'b1};

    rst_n = 1'b0; n_en = 1'b1; rnw = 1'b1; addr = 8'd0; tb_bus = 256'd0; tb_drv = 1'b0;
    #12;
    check("rst_mem_done", {255'd0, mem_done}, 256'd0);
    check("rst_addr_err", {255'd0, addr_err}, 256'd0);
    check("rst_bus_drive", {255'd0, bus_drive}, 256'd0);
`ifdef MATRIX_MEM_PARITY_EN
    check("rst_parity_err", {255'd0, parity_err}, 256'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rnw) do_read(vecs[i].addr, vecs[i].data, vecs[i].exp_err, 1'b0);
      else             do_write(vecs[i].addr, vecs[i].data, vecs[i].exp_err);
    end

    // Out-of-range writes must have left every entry untouched.
    for (int i = 0; i < 16; i++) do_read(8'(i), model[i], 1'b0, 1'b0);

    // Read/write switch during drive: drive stops, no write without a fresh request.
    do_write(8'd9, {16{16'h1234}}, 1'b0);
    sbq.push_back('{1'b1, {16{16'h1234}}, 1'b0, 1'b0});
    n_en = 1'b0; rnw = 1'b1; addr = 8'd9;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sw_driving", {255'd0, bus_drive}, 256'd1);
    rnw = 1'b0;
    @(posedge clk); #1;
    check("sw_drive_stop", {255'd0, bus_drive}, 256'd0);
    tb_bus = {16{16'h5678}}; tb_drv = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("sw_no_write_done", {255'd0, mem_done}, 256'd0);
    tb_drv = 1'b0; n_en = 1'b1;
    @(posedge clk); #1;
    do_read(8'd9, {16{16'h1234}}, 1'b0, 1'b0);
    do_write(8'd9, {16{16'h5678}}, 1'b0);
    do_read(8'd9, {16{16'h5678}}, 1'b0, 1'b0);

    // Enable released during access: one drive cycle only.
    sbq.push_back('{1'b1, pat, 1'b0, 1'b0});
    n_en = 1'b0; rnw = 1'b1; addr = 8'd3;
    @(posedge clk); #1;
    n_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("acc_rel_drive", {255'd0, bus_drive}, 256'd1);
    @(posedge clk); #1;
    check("acc_rel_one_cycle", {255'd0, bus_drive}, 256'd0);

    // Reset during drive: bus released at once, array cleared.
    do_write(8'd5, ones, 1'b0);
    sbq.push_back('{1'b1, ones, 1'b0, 1'b0});
    n_en = 1'b0; rnw = 1'b1; addr = 8'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_driving", {255'd0, bus_drive}, 256'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_drive_off", {255'd0, bus_drive}, 256'd0);
    check("rst_async_done_off", {255'd0, mem_done}, 256'd0);
    n_en = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 256'd0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(8'd5, 256'd0, 1'b0, 1'b0);
    do_read(8'd9, 256'd0, 1'b0, 1'b0);

`ifdef MATRIX_MEM_PARITY_EN
    do_write(8'd7, {16{16'h0F0F}}, 1'b0);
    do_read(8'd7, {16{16'h0F0F}}, 1'b0, 1'b0);
    force dut.r_mem[7] = {16{16'h0F0F}} ^ 256'd1;
    do_read(8'd7, {16{16'h0F0F}} ^ 256'd1, 1'b0, 1'b1);
    release dut.r_mem[7];
`endif

    repeat (2) @(posedge clk);
    check("sb_drain", 256'(sbq.size()), 256'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
